// File: rtl/spi_shifter_pkg.sv
// Shared types and widths for the SPI master serial engine.
package SPI_package;
  localparam int SPI_DATA_WIDTH = 32;
  localparam int SPI_BR_WIDTH   = 8;
  localparam int SPI_LEN_WIDTH  = $clog2(SPI_DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

  typedef struct packed {
    logic                     cpol;
    logic                     cpha;
    logic [SPI_BR_WIDTH-1:0]  br;
    logic [SPI_LEN_WIDTH-1:0] datalen;
  } spi_frame_cfg;
endpackage

// File: rtl/spi_clkgen.sv
// SCLK pacing: half-period counter plus edge counter, emitting per-edge strobes.
module spi_clkgen
  import SPI_package::*;
#(
  parameter int BRW = SPI_BR_WIDTH,
  parameter int LW  = SPI_LEN_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hp_en,
  input  logic           edge_en,
  input  logic [BRW-1:0] br,
  input  logic [LW-1:0]  datalen,
  output logic           tick,
  output logic           lead_edge,
  output logic           trail_edge,
  output logic           first_edge,
  output logic           last_edge
);
  logic [BRW-1:0] hp_q, hp_d;
  logic [LW:0]    ecnt_q, ecnt_d;
  logic           edge_tick;

  always_comb begin
    tick       = hp_en && (hp_q == br);
    edge_tick  = edge_en && tick;
    hp_d       = (!hp_en || tick) ? '0 : hp_q + 1'b1;
    ecnt_d     = !edge_en ? '0 : (edge_tick ? ecnt_q + 1'b1 : ecnt_q);
    // ecnt_q holds edges already produced, so even count means an odd (leading) edge
    lead_edge  = edge_tick && !ecnt_q[0];
    trail_edge = edge_tick && ecnt_q[0];
    first_edge = edge_tick && (ecnt_q == '0);
    last_edge  = edge_tick && (ecnt_q == {datalen, 1'b1});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q   <= '0;
      ecnt_q <= '0;
    end else begin
      hp_q   <= hp_d;
      ecnt_q <= ecnt_d;
    end
  end
endmodule

// File: rtl/spi_shifter.sv
// SPI master engine: pops TFIFO words, shifts them out on MOSI while
// collecting MISO, and pushes the received word into the RFIFO.
module spi_shifter
  import SPI_package::*;
#(
  parameter int DW  = SPI_DATA_WIDTH,
  parameter int BRW = SPI_BR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [BRW-1:0]         br,
  input  logic [$clog2(DW)-1:0]  datalen,
  input  logic [DW-1:0]          transfer_data,
  input  logic                   tfifo_empty,
  output logic                   tfifo_ren,
  input  logic                   rfifo_full,
  output logic [DW-1:0]          receive_data,
  output logic                   rfifo_wen,
  input  logic                   ovr_clr,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   ss_n,
  input  logic                   miso,
  output logic                   busy,
  output logic                   overrun
);
  spi_state_e   state_q, state_d;
  spi_frame_cfg cfg_q, cfg_d;
  logic [DW-1:0] sreg_q, sreg_d, rx_q, rx_d;
  logic push_q, push_d, sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
  logic ren_q, ren_d, wen_q, wen_d, busy_q, busy_d, ovr_q, ovr_d;
  logic start, hp_en, edge_en, shift_now, sample_now;
  logic tick, lead_edge, trail_edge, first_edge, last_edge;

  spi_clkgen #(.BRW(BRW), .LW($clog2(DW))) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .hp_en      (hp_en),
    .edge_en    (edge_en),
    .br         (cfg_q.br),
    .datalen    (cfg_q.datalen),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .first_edge (first_edge),
    .last_edge  (last_edge)
  );

  always_comb begin
    start      = (state_q == IDLE) && enable && !tfifo_empty;
    edge_en    = (state_q == SHIFT) && !push_q;
    hp_en      = (state_q == SETUP) || (state_q == HOLD) || edge_en;
    // MSB is already on the wire before the first edge, so cpha=1 skips that shift
    shift_now  = cfg_q.cpha ? (lead_edge && !first_edge) : (trail_edge && !last_edge);
    sample_now = cfg_q.cpha ? trail_edge : lead_edge;

    state_d = state_q;
    cfg_d   = cfg_q;
    sreg_d  = sreg_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    push_d  = 1'b0;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    ovr_d   = ovr_q & ~ovr_clr;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start) begin
          state_d       = SETUP;
          cfg_d.cpol    = cpol;
          cfg_d.cpha    = cpha;
          cfg_d.br      = br;
          cfg_d.datalen = datalen;
          sreg_d        = transfer_data;
          rx_d          = '0;
          ren_d         = 1'b1;
        end
      end
      SETUP: begin
        sclk_d = cfg_q.cpol;
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (lead_edge || trail_edge) sclk_d = ~sclk_q;
        if (shift_now)  sreg_d = {sreg_q[DW-2:0], 1'b0};
        if (sample_now) rx_d   = {rx_q[DW-2:0], miso};
        if (last_edge) begin
          push_d = 1'b1;
          wen_d  = !rfifo_full;
          if (rfifo_full) ovr_d = 1'b1;
        end
        if (push_q) state_d = HOLD;
      end
      default: begin
        sclk_d = cfg_q.cpol;
        if (tick) state_d = IDLE;
      end
    endcase

    ss_n_d = !((state_q == SETUP) || (state_q == SHIFT));
    mosi_d = ss_n_d ? mosi_q : sreg_d[cfg_q.datalen];
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      sreg_q  <= '0;
      rx_q    <= '0;
      push_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      sreg_q  <= sreg_d;
      rx_q    <= rx_d;
      push_q  <= push_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;
  assign tfifo_ren    = ren_q;
  assign rfifo_wen    = wen_q;
  assign receive_data = rx_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_spi_shifter.sv
// Randomized bench: pin-level frame monitor checked against a per-frame model.
module tb_spi_shifter;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0]  br = 8'd0;
  logic [4:0]  datalen = 5'd0;
  logic [31:0] transfer_data, receive_data;
  logic        tfifo_empty, tfifo_ren, rfifo_wen, sclk, mosi, ss_n, miso, busy, overrun;
  logic        rfifo_full = 1'b0, ovr_clr = 1'b0;
  logic        tie_en = 1'b0, tie_val = 1'b0, inv = 1'b0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  spi_shifter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cpol(cpol), .cpha(cpha), .br(br),
    .datalen(datalen), .transfer_data(transfer_data), .tfifo_empty(tfifo_empty),
    .tfifo_ren(tfifo_ren), .rfifo_full(rfifo_full), .receive_data(receive_data),
    .rfifo_wen(rfifo_wen), .ovr_clr(ovr_clr), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .busy(busy), .overrun(overrun)
  );

  // Transmit FIFO model with fall-through head
  logic [31:0] tq [0:63];
  int wr_ptr = 0, rd_ptr = 0;
  assign transfer_data = tq[rd_ptr[5:0]];
  assign tfifo_empty   = (rd_ptr == wr_ptr);
  always @(posedge clk) if (tfifo_ren) rd_ptr <= rd_ptr + 1;

  assign miso = tie_en ? tie_val : (mosi ^ inv);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    tq[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // Pin monitor: one record per completed ss_n-low window
  int cyc = 0, ren_cnt = 0, wen_cnt = 0, both_cnt = 0, ren_cyc = 0;
  logic [31:0] rxq[$];
  logic [31:0] f_mosi[$];
  int f_edges[$], f_low[$], f_ivmin[$], f_ivmax[$], f_gap[$], f_r2s[$];
  logic f_pols[$], f_pole[$];
  bit in_fr = 0, ss_p = 1, sclk_p = 0;
  int nedge = 0, low_c = 0, hi_c = 0, ivmin = 0, ivmax = 0, last_e = 0, gap = 0, r2s = 0;
  logic [31:0] cap = '0;
  logic pol_s = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rfifo_wen) begin wen_cnt++; rxq.push_back(receive_data); end
      if (tfifo_ren && rfifo_wen) both_cnt++;
      if (!rst_n) begin
        in_fr = 0; ss_p = 1; sclk_p = sclk; hi_c = 0;
      end else begin
        if (tfifo_ren) begin ren_cnt++; ren_cyc = cyc; end
        if (ss_p && !ss_n) begin
          in_fr = 1; nedge = 0; low_c = 0; cap = '0; ivmin = 1000000; ivmax = 0;
          gap = hi_c; hi_c = 0; r2s = cyc - ren_cyc; pol_s = sclk;
        end
        if (ss_n) hi_c++;
        if (in_fr && !ss_n) begin
          low_c++;
          if (sclk != sclk_p) begin
            if (nedge > 0) begin
              if (cyc - last_e < ivmin) ivmin = cyc - last_e;
              if (cyc - last_e > ivmax) ivmax = cyc - last_e;
            end
            last_e = cyc;
            nedge++;
            if ((nedge % 2 == 1) == (cpha == 1'b0)) cap = {cap[30:0], mosi};
          end
        end
        if (in_fr && !ss_p && ss_n) begin
          f_edges.push_back(nedge); f_mosi.push_back(cap); f_low.push_back(low_c);
          f_ivmin.push_back(ivmin); f_ivmax.push_back(ivmax); f_gap.push_back(gap);
          f_r2s.push_back(r2s); f_pols.push_back(pol_s); f_pole.push_back(sclk);
          in_fr = 0;
        end
        ss_p = ss_n; sclk_p = sclk;
      end
    end
  end

  int fr_rd = 0, rx_rd = 0;

  // Model: n-bit frame, MSB first; ss_n low for setup + 2n half-periods + push cycle
  task automatic check_frame(input logic [31:0] w, input bit exp_push, input bit chk_gap);
    int n, hp, budget;
    logic [31:0] mask, exp_rx;
    n = int'(datalen) + 1;
    hp = int'(br) + 1;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    exp_rx = tie_en ? (tie_val ? mask : 32'h0) : ((w ^ {32{inv}}) & mask);
    budget = 0;
    while (f_edges.size() <= fr_rd && budget < 5000) begin @(negedge clk); budget++; end
    if (f_edges.size() <= fr_rd) begin chk("frame_timeout", 32'd0, 32'd1); return; end
    chk("edges", f_edges[fr_rd], 2 * n);
    chk("mosi_bits", f_mosi[fr_rd], w & mask);
    chk("ss_low_cycles", f_low[fr_rd], hp * (2 * n + 1) + 1);
    chk("half_period_min", f_ivmin[fr_rd], (n > 0) ? hp : 0);
    chk("half_period_max", f_ivmax[fr_rd], hp);
    chk("ren_to_ss", f_r2s[fr_rd], 1);
    chk("sclk_idle_start", f_pols[fr_rd], cpol);
    chk("sclk_idle_end", f_pole[fr_rd], cpol);
    if (chk_gap) chk("ss_gap", f_gap[fr_rd], int'(br) + 2);
    if (exp_push) begin
      if (rxq.size() <= rx_rd) chk("rx_missing", 32'd0, 32'd1);
      else begin chk("rx_word", rxq[rx_rd], exp_rx); rx_rd++; end
    end
    fr_rd++;
  endtask

  task automatic set_cfg(input logic p, input logic h, input int b, input int d);
    cpol = p; cpha = h; br = 8'(b); datalen = 5'(d);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, w1;
    int base, budget;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_tfifo_ren", tfifo_ren, 0);
    chk("rst_rfifo_wen", rfifo_wen, 0);
    chk("rst_receive_data", receive_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1; enable = 1'b1;

    // Mode 0 loopback of 0xA5
    set_cfg(0, 0, 0, 7);
    @(negedge clk); push_word(32'hA5);
    check_frame(32'hA5, 1, 0);

    // Mode 3, MISO tied high
    set_cfg(1, 1, 3, 15); tie_en = 1'b1; tie_val = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_sclk_cpol1", sclk, 1);
    push_word(32'h1234);
    check_frame(32'h1234, 1, 0);
    tie_en = 1'b0;

    // Two full-width words back to back
    set_cfg(0, 1, 2, 31);
    @(negedge clk); push_word(32'hDEADBEEF); push_word(32'h0F0F0F0F);
    check_frame(32'hDEADBEEF, 1, 0);
    check_frame(32'h0F0F0F0F, 1, 1);

    // Randomized frames
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_cfg(1'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 31));
      tie_en = ($urandom_range(0, 3) == 0); tie_val = 1'($urandom); inv = 1'($urandom);
      w0 = $urandom;
      push_word(w0);
      check_frame(w0, 1, 0);
    end
    tie_en = 1'b0; inv = 1'b0;

    // Overrun: dropped word, clear, then set-beats-clear
    @(negedge clk);
    set_cfg(0, 0, 1, 7); rfifo_full = 1'b1;
    base = wen_cnt;
    push_word(32'h3C);
    check_frame(32'h3C, 0, 0);
    chk("ovr_no_wen", wen_cnt, base);
    chk("ovr_set", overrun, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    ovr_clr = 1'b1;
    push_word(32'h5A);
    seen = 0; budget = 0;
    while (!seen && budget < 3000) begin
      @(negedge clk); budget++;
      if (overrun) seen = 1;
    end
    chk("ovr_set_priority", seen, 1);
    check_frame(32'h5A, 0, 0);
    ovr_clr = 1'b0; rfifo_full = 1'b0;

    // Enable dropped mid-frame with 3 queued words
    @(negedge clk);
    set_cfg(0, 0, 1, 7);
    base = ren_cnt;
    w0 = $urandom; w1 = $urandom;
    push_word(w0); push_word(w1); push_word($urandom);
    budget = 0;
    while (ren_cnt == base && budget < 100) begin @(negedge clk); budget++; end
    enable = 1'b0;
    check_frame(w0, 1, 0);
    budget = 0;
    while (busy && budget < 100) begin @(negedge clk); budget++; end
    chk("en_drop_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("en_drop_ren_once", ren_cnt - base, 1);
    chk("en_drop_fifo_left", wr_ptr - rd_ptr, 2);

    // Reset during SHIFT
    base = ren_cnt;
    enable = 1'b1;
    budget = 0;
    while (ren_cnt == base && budget < 100) begin @(negedge clk); budget++; end
    budget = 0;
    while (!(in_fr && nedge >= 3) && budget < 200) begin @(negedge clk); budget++; end
    chk("rst_mid_reached_shift", (in_fr && nedge >= 3), 1);
    base = wen_cnt;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("rst_mid_ss_n", ss_n, 1);
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_wen", wen_cnt, base);
    chk("ren_wen_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
